// File: rtl/mhp_pkg.sv
// Shared types and constants for the MHP responder: frame header layout,
// request opcodes and the responder FSM state encoding.
package mhp_pkg;

  localparam int         MHP_HDR_BYTES   = 7;
  localparam logic [6:0] MHP_OP_A        = 7'h01;
  localparam logic [6:0] MHP_OP_B        = 7'h03;
  localparam logic [6:0] MHP_OP_C        = 7'h05;
  localparam logic [7:0] MHP_DTYPE_GRANT = 8'h04;

  typedef enum logic [1:0] {RX_HDR, RX_PAY, CHECK, TX_HDR} mhp_state_e;

  // Packed so that dst lands in the top bits: shifting bytes in big-endian
  // order fills the struct directly.
  typedef struct packed {
    logic [15:0] dst;
    logic [15:0] src;
    logic [15:0] size;
    logic [7:0]  dtype;
  } mhp_hdr_t;

  function automatic logic [7:0] mhp_hdr_byte(input mhp_hdr_t h, input logic [2:0] idx);
    case (idx)
      3'd0:    return h.dst[15:8];
      3'd1:    return h.dst[7:0];
      3'd2:    return h.src[15:8];
      3'd3:    return h.src[7:0];
      3'd4:    return h.size[15:8];
      3'd5:    return h.size[7:0];
      default: return h.dtype;
    endcase
  endfunction

  function automatic logic mhp_is_request(input logic [7:0] dtype);
    return dtype[7] && (dtype[6:0] == MHP_OP_A || dtype[6:0] == MHP_OP_B ||
                        dtype[6:0] == MHP_OP_C);
  endfunction

endpackage

// File: rtl/mhp_hdr_ser.sv
// 7-byte header serializer: a start pulse captures the first byte; each
// valid/ready transfer advances to the next byte. o_data is registered.
module mhp_hdr_ser
  import mhp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  mhp_hdr_t   i_hdr,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last
);

  logic [2:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       xfer;

  assign xfer    = valid_q && i_ready;
  assign o_last  = xfer && (idx_q == 3'(MHP_HDR_BYTES - 1));
  assign o_valid = valid_q;
  assign o_data  = data_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (i_start) begin
      valid_d = 1'b1;
      idx_d   = '0;
      data_d  = mhp_hdr_byte(i_hdr, 3'd0);
    end else if (xfer) begin
      if (o_last) begin
        valid_d = 1'b0;
      end else begin
        idx_d  = idx_q + 3'd1;
        data_d = mhp_hdr_byte(i_hdr, idx_q + 3'd1);
      end
    end
  end

endmodule

// File: rtl/mhp_responder.sv
// MHP responder: receives request frames, discards payload, and answers
// each valid request with a grant carrying a freshly allocated address.
module mhp_responder
  import mhp_pkg::*;
#(
  parameter logic [15:0] MY_ADDR     = 16'h0000,
  parameter logic [15:0] ADDR_BASE   = 16'h0100,
  parameter logic [15:0] ADDR_LAST   = 16'h01FF,
  parameter logic [7:0]  GRANT_DTYPE = MHP_DTYPE_GRANT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [7:0]  i_rdata,
  input  logic        i_rready,
  output logic        o_rreq,
  output logic [7:0]  o_wdata,
  input  logic        i_wready,
  output logic        o_wvalid,
  output logic        o_grant_strobe,
  output logic [15:0] o_grant_addr,
  output logic [6:0]  o_req_opcode,
  output logic        o_busy,
  output logic [7:0]  o_err_cnt
);

  mhp_state_e  state_q, state_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  mhp_hdr_t    rx_hdr_q, rx_hdr_d, tx_hdr_q, tx_hdr_d;
  logic [15:0] rem_q, rem_d, alloc_q, alloc_d, gaddr_q, gaddr_d;
  logic [6:0]  op_q, op_d;
  logic [7:0]  err_q, err_d;
  logic        start_q, start_d, rreq_q, rreq_d;
  logic        rx_xfer, ser_last;

  assign rx_xfer        = rreq_q && i_rready;
  assign o_rreq         = rreq_q;
  assign o_grant_strobe = ser_last;
  assign o_grant_addr   = gaddr_q;
  assign o_req_opcode   = op_q;
  assign o_err_cnt      = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RX_HDR;
      rx_idx_q <= '0;
      rx_hdr_q <= '0;
      tx_hdr_q <= '0;
      rem_q    <= '0;
      alloc_q  <= ADDR_BASE;
      gaddr_q  <= '0;
      op_q     <= '0;
      err_q    <= '0;
      start_q  <= 1'b0;
      rreq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_idx_q <= rx_idx_d;
      rx_hdr_q <= rx_hdr_d;
      tx_hdr_q <= tx_hdr_d;
      rem_q    <= rem_d;
      alloc_q  <= alloc_d;
      gaddr_q  <= gaddr_d;
      op_q     <= op_d;
      err_q    <= err_d;
      start_q  <= start_d;
      rreq_q   <= rreq_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rx_idx_d = rx_idx_q;
    rx_hdr_d = rx_hdr_q;
    tx_hdr_d = tx_hdr_q;
    rem_d    = rem_q;
    alloc_d  = alloc_q;
    gaddr_d  = gaddr_q;
    op_d     = op_q;
    err_d    = err_q;
    start_d  = 1'b0;
    case (state_q)
      RX_HDR: if (rx_xfer) begin
        rx_hdr_d = {rx_hdr_q[47:0], i_rdata};
        if (rx_idx_q == 3'(MHP_HDR_BYTES - 1)) begin
          // Size bytes already sit in the low 16 bits before dtype shifts in.
          rx_idx_d = '0;
          rem_d    = rx_hdr_q[15:0];
          state_d  = (rx_hdr_q[15:0] != 16'h0000) ? RX_PAY : CHECK;
        end else begin
          rx_idx_d = rx_idx_q + 3'd1;
        end
      end
      RX_PAY: if (rx_xfer) begin
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) state_d = CHECK;
      end
      CHECK: begin
        if (mhp_is_request(rx_hdr_q.dtype)) begin
          op_d     = rx_hdr_q.dtype[6:0];
          tx_hdr_d = '{dst: alloc_q, src: MY_ADDR, size: 16'h0000, dtype: GRANT_DTYPE};
          start_d  = 1'b1;
          state_d  = TX_HDR;
        end else begin
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          state_d = RX_HDR;
        end
      end
      default: if (ser_last) begin
        gaddr_d = alloc_q;
        alloc_d = (alloc_q == ADDR_LAST) ? ADDR_BASE : alloc_q + 16'd1;
        state_d = RX_HDR;
      end
    endcase
  end

  always_comb begin
    rreq_d = ((state_d == RX_HDR) && (i_enable || (rx_idx_d != 3'd0))) ||
             (state_d == RX_PAY);
    o_busy = !((state_q == RX_HDR) && (rx_idx_q == 3'd0));
  end

  mhp_hdr_ser u_ser (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (start_q),
    .i_hdr   (tx_hdr_q),
    .i_ready (i_wready),
    .o_valid (o_wvalid),
    .o_data  (o_wdata),
    .o_last  (ser_last)
  );

endmodule
